// File: rtl/dbus_sram_responder.sv
// Slave end of the LSU data-bus request/ack protocol, backed by a word-wide
// single-port SRAM with byte-lane writes and a fixed wait-state count.
module dbus_sram_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_i,
  input  logic        w_en_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  input  logic        flush_i,
  output logic [31:0] rdata_o,
  output logic        ack_o,
  output logic        err_o
);

  localparam int          AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN_MASK = ~(32'(DEPTH_WORDS) * 32'd4 - 32'd1);
  localparam logic [3:0]  CNT_INIT  = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_p0;
  logic [31:0] wdata_p0;
  logic [3:0]  sel_p0;
  logic        w_en_p0;
  logic [31:0] mem [DEPTH_WORDS];

  logic          accept;
  logic          go_resp;
  logic          cur_w_en;
  logic [31:0]   cur_addr;
  logic [AW-1:0] cur_idx;
  logic [AW-1:0] wr_idx;

  // BASE_ADDR is span-aligned, so in-range means the upper bits match the base.
  function automatic logic in_range(input logic [31:0] a);
    return ((a ^ BASE_ADDR) & SPAN_MASK) == 32'd0;
  endfunction

  // With zero wait states the read happens on the sampling edge itself,
  // before the captured copy exists, so the live inputs are used there.
  always_comb begin
    accept   = (state == IDLE) && req_i && !flush_i;
    go_resp  = (accept && (WAIT_STATES == 0)) ||
               ((state == WAIT) && !flush_i && (cnt == 4'd0));
    cur_addr = (state == IDLE) ? addr_i : addr_p0;
    cur_w_en = (state == IDLE) ? w_en_i : w_en_p0;
    cur_idx  = cur_addr[AW+1:2];
    wr_idx   = addr_p0[AW+1:2];
  end

  // p0: request capture
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0  <= addr_i;
      wdata_p0 <= wdata_i;
      sel_p0   <= sel_i;
      w_en_p0  <= w_en_i;
    end
  end

  // Write commits on the edge that ends RESP
  always_ff @(posedge clk) begin
    if (rst_n && (state == RESP) && w_en_p0 && in_range(addr_p0)) begin
      for (int n = 0; n < 4; n++) begin
        if (sel_p0[n]) mem[wr_idx][8*n +: 8] <= wdata_p0[8*n +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
    end else begin
      ack_o   <= 1'b0;
      err_o   <= 1'b0;
      rdata_o <= 32'd0;
      if (go_resp) begin
        ack_o   <= 1'b1;
        err_o   <= !in_range(cur_addr);
        rdata_o <= (in_range(cur_addr) && !cur_w_en) ? mem[cur_idx] : 32'd0;
      end
      case (state)
        IDLE: begin
          if (accept) begin
            state <= (WAIT_STATES == 0) ? RESP : WAIT;
            cnt   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (flush_i)            state <= IDLE;
          else if (cnt == 4'd0)   state <= RESP;
          else                    cnt   <= cnt - 4'd1;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
